truth_sweep_ctrl: RTL and testbench

Sequencer that sweeps every input combination through two gate-level implementations of the same boolean function and checks them for equivalence. It replaces the hand-written `#1` stimulus blocks with one synthesizable controller. The controller drives a shared N-bit input vector to both implementations, waits a programmable settle time, and compares their outputs. It accumulates a mismatch count, captures the first failing vector and raises done/pass at the end of the sweep.

---
 rtl/truth_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_truth_sweep_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: walks every N-bit input vector through two implementations
// of one boolean function, holds each vector SETTLE cycles, then compares the
// two outputs for one cycle. Reports mismatch count, first failing vector and
// a pass flag at the end of the sweep.
module truth_sweep_ctrl #(
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic         a_in,
    input  logic         b_in,
    output logic [N-1:0] x,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   mismatch_count,
    output logic [N-1:0] first_fail,
    output logic         fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [N-1:0] LAST_VEC    = '1;
    localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_settle;
    logic [N-1:0] r_x;
    logic [N:0]   r_count;
    logic [N-1:0] r_first;
    logic         r_fvalid;
    logic         r_pass;

    logic         w_settled;
    logic         w_last;
    logic         w_miss;

    assign w_settled = (r_settle == SETTLE_LAST);
    // Last vector is detected by equality so x never wraps inside a sweep.
    assign w_last    = (r_x == LAST_VEC);
    assign w_miss    = (r_state == S_CHECK) && (a_in != b_in);

    assign x              = r_x;
    assign pass           = r_pass;
    assign mismatch_count = r_count;
    assign first_fail     = r_first;
    assign fail_valid     = r_fvalid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_APPLY;
                end
            end
            S_APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_settled) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_APPLY;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector counter, settle timer and result accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle <= '0;
            r_x      <= '0;
            r_count  <= '0;
            r_first  <= '0;
            r_fvalid <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_settle <= '0;
                        r_x      <= '0;
                        r_count  <= '0;
                        r_first  <= '0;
                        r_fvalid <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (abort || w_settled) begin
                        r_settle <= '0;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                    if (abort) begin
                        r_pass <= 1'b0;
                    end
                end
                S_CHECK: begin
                    // The compare on the CHECK edge is kept even when abort
                    // is taken, so partial results include this vector.
                    if (w_miss) begin
                        r_count <= r_count + (N+1)'(1);
                        if (!r_fvalid) begin
                            r_first  <= r_x;
                            r_fvalid <= 1'b1;
                        end
                    end
                    if (abort) begin
                        r_pass <= 1'b0;
                    end else if (w_last) begin
                        r_pass <= (r_count == '0) && !w_miss;
                    end else begin
                        r_x <= r_x + N'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed bench for truth_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// driven by small gate-level models of the function under comparison.
module tb_truth_sweep_ctrl;

    logic clk = 1'b0;
    logic reset;

    // Instance 1: N=2, SETTLE=1
    logic       start1, abort1, a1, b1;
    logic [1:0] x1;
    logic       busy1, done1, pass1, fv1;
    logic [2:0] cnt1;
    logic [1:0] ff1;
    logic [1:0] mode1;

    // Instance 2: N=2, SETTLE=3
    logic       start2, abort2, a2, b2;
    logic [1:0] x2;
    logic       busy2, done2, pass2, fv2;
    logic [2:0] cnt2;
    logic [1:0] ff2;
    logic       glitch2;

    int tests = 0;
    int fails = 0;

    truth_sweep_ctrl #(.N(2), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .a_in(a1), .b_in(b1), .x(x1), .busy(busy1), .done(done1),
        .pass(pass1), .mismatch_count(cnt1), .first_fail(ff1),
        .fail_valid(fv1)
    );

    truth_sweep_ctrl #(.N(2), .SETTLE(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .a_in(a2), .b_in(b2), .x(x2), .busy(busy2), .done(done2),
        .pass(pass2), .mismatch_count(cnt2), .first_fail(ff2),
        .fail_valid(fv2)
    );

    always #5 clk = ~clk;

    function automatic logic nand2(input logic p, input logic q);
        return ~(p & q);
    endfunction

    // NOR built only from NAND gates.
    function automatic logic nand_nor(input logic p, input logic q);
        logic o;
        o = nand2(nand2(p, p), nand2(q, q));
        return nand2(o, o);
    endfunction

    // Implementations under comparison; mode1=1 selects a NAND as B.
    always_comb begin
        a1 = nand_nor(x1[1], x1[0]);
        b1 = (mode1 == 2'd1) ? (~x1[1] | ~x1[0]) : ~(x1[1] | x1[0]);
        a2 = nand_nor(x2[1], x2[0]);
        b2 = ~(x2[1] | x2[0]) ^ glitch2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sweep on instance 1 from IDLE, with optional stray start pulses.
    task automatic sweep1(input string nm, input int exp_cnt, input int exp_ff,
                          input int exp_fv, input int exp_pass, input bit extra_starts);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk({nm, " cnt cleared"}, 32'(cnt1), 32'd0);
        chk({nm, " fv cleared"}, 32'(fv1), 32'd0);
        chk({nm, " ff cleared"}, 32'(ff1), 32'd0);
        chk({nm, " pass cleared"}, 32'(pass1), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("%s x c%0d", nm, c), 32'(x1), 32'((c - 1) / 2));
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy1), 32'd1);
            chk($sformatf("%s done c%0d", nm, c), 32'(done1), 32'd0);
            if (extra_starts && c == 3) start1 = 1'b1;
            tick;
            start1 = 1'b0;
        end
        chk({nm, " done c9"}, 32'(done1), 32'd1);
        chk({nm, " busy c9"}, 32'(busy1), 32'd0);
        chk({nm, " x c9"}, 32'(x1), 32'd3);
        chk({nm, " cnt"}, 32'(cnt1), 32'(exp_cnt));
        chk({nm, " first_fail"}, 32'(ff1), 32'(exp_ff));
        chk({nm, " fail_valid"}, 32'(fv1), 32'(exp_fv));
        chk({nm, " pass"}, 32'(pass1), 32'(exp_pass));
        if (extra_starts) start1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk({nm, " done c10"}, 32'(done1), 32'd0);
        chk({nm, " busy c10"}, 32'(busy1), 32'd0);
        chk({nm, " x held c10"}, 32'(x1), 32'd3);
        chk({nm, " pass held c10"}, 32'(pass1), 32'(exp_pass));
        tick;
        chk({nm, " done c11"}, 32'(done1), 32'd0);
        chk({nm, " busy c11"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start1  = 1'b0;
        abort1  = 1'b0;
        mode1   = 2'd0;
        start2  = 1'b0;
        abort2  = 1'b0;
        glitch2 = 1'b0;
        tick;
        tick;

        // Reset state of both instances.
        chk("rst x1", 32'(x1), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst done1", 32'(done1), 32'd0);
        chk("rst pass1", 32'(pass1), 32'd0);
        chk("rst cnt1", 32'(cnt1), 32'd0);
        chk("rst ff1", 32'(ff1), 32'd0);
        chk("rst fv1", 32'(fv1), 32'd0);
        chk("rst x2", 32'(x2), 32'd0);
        chk("rst busy2", 32'(busy2), 32'd0);
        chk("rst cnt2", 32'(cnt2), 32'd0);
        reset = 1'b0;
        tick;

        // Equivalent implementations; stray starts at cycles 3 and 9.
        mode1 = 2'd0;
        sweep1("equiv", 0, 0, 0, 1, 1'b1);

        // NOR vs NAND: mismatches at 01 and 10.
        mode1 = 2'd1;
        sweep1("mism", 2, 1, 1, 0, 1'b0);

        // Abort in CHECK of vector 01 (cycle 4).
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick;
        tick;
        tick;
        chk("abort pre x", 32'(x1), 32'd1);
        chk("abort pre busy", 32'(busy1), 32'd1);
        abort1 = 1'b1;
        tick;
        abort1 = 1'b0;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort done", 32'(done1), 32'd0);
        chk("abort pass", 32'(pass1), 32'd0);
        chk("abort cnt", 32'(cnt1), 32'd1);
        chk("abort ff", 32'(ff1), 32'd1);
        chk("abort fv", 32'(fv1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("abort idle done %0d", i), 32'(done1), 32'd0);
            chk($sformatf("abort idle busy %0d", i), 32'(busy1), 32'd0);
        end

        // Abort together with start in IDLE: start wins; then abort in APPLY.
        start1 = 1'b1;
        abort1 = 1'b1;
        tick;
        start1 = 1'b0;
        chk("start+abort busy", 32'(busy1), 32'd1);
        chk("start+abort x", 32'(x1), 32'd0);
        tick;
        chk("apply abort busy", 32'(busy1), 32'd0);
        abort1 = 1'b0;
        tick;

        // Asynchronous reset between edges during APPLY of vector 10.
        mode1 = 2'd1;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick;
        tick;
        tick;
        tick;
        chk("pre-rst x", 32'(x1), 32'd2);
        chk("pre-rst cnt", 32'(cnt1), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst x", 32'(x1), 32'd0);
        chk("async rst busy", 32'(busy1), 32'd0);
        chk("async rst cnt", 32'(cnt1), 32'd0);
        chk("async rst ff", 32'(ff1), 32'd0);
        chk("async rst fv", 32'(fv1), 32'd0);
        chk("async rst pass", 32'(pass1), 32'd0);
        reset = 1'b0;
        mode1 = 2'd0;
        sweep1("post-rst", 0, 0, 0, 1, 1'b0);

        // SETTLE=3: b_in glitches during the three settle cycles of each vector.
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < 4; c++) begin
                glitch2 = (c < 3);
                chk($sformatf("s3 x v%0d c%0d", v, c), 32'(x2), 32'(v));
                chk($sformatf("s3 busy v%0d c%0d", v, c), 32'(busy2), 32'd1);
                chk($sformatf("s3 done v%0d c%0d", v, c), 32'(done2), 32'd0);
                tick;
            end
        end
        glitch2 = 1'b0;
        chk("s3 done c17", 32'(done2), 32'd1);
        chk("s3 busy c17", 32'(busy2), 32'd0);
        chk("s3 cnt", 32'(cnt2), 32'd0);
        chk("s3 fv", 32'(fv2), 32'd0);
        chk("s3 pass", 32'(pass2), 32'd1);
        tick;
        chk("s3 done c18", 32'(done2), 32'd0);
        chk("s3 x held", 32'(x2), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
